// File: rtl/intr_pkg.sv
// intr_pkg: shared types and constants for the interrupt controller
// Contents: FSM state type, source bit indices, default timer period.
package intr_pkg;
    typedef enum logic [1:0] {IDLE, FIRE, SERVICE} state_t;
    localparam int SRC_EXT = 0;
    localparam int SRC_TMR = 1;
    localparam logic [9:0] DEF_PERIOD = 10'd1000;
endpackage

// File: rtl/intr_timer.sv
// intr_timer: periodic tick generator for the interrupt controller
// Ports: clk, reset (sync, active-high), i_en (count enable), o_tick (one-cycle tick).
// With INTR_TIMER_RELOAD_EN defined: i_reload_we / i_reload_wd load the period
// register (clamped to >= 2) and zero the counter.
module intr_timer
    import intr_pkg::*;
#(
    parameter logic [9:0] PERIOD = DEF_PERIOD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_en,
`ifdef INTR_TIMER_RELOAD_EN
    input  logic       i_reload_we,
    input  logic [9:0] i_reload_wd,
`endif
    output logic       o_tick
);
    logic [9:0] r_cnt;
    logic [9:0] w_per;
    logic       w_load;
`ifdef INTR_TIMER_RELOAD_EN
    logic [9:0] r_per;
    assign w_per  = r_per;
    assign w_load = i_reload_we;
    always_ff @(posedge clk) begin
        if (reset)
            r_per <= PERIOD;
        else if (i_reload_we)
            r_per <= (i_reload_wd < 10'd2) ? 10'd2 : i_reload_wd;
    end
`else
    assign w_per  = PERIOD;
    assign w_load = 1'b0;
`endif
    // a reload restarts the count, so no tick is issued in that cycle
    assign o_tick = i_en & ~w_load & (r_cnt == w_per - 10'd1);
    always_ff @(posedge clk) begin
        if (reset || w_load)
            r_cnt <= '0;
        else if (o_tick)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + 10'd1;
    end
endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl: interrupt request initiator for the single-cycle CPU
// Ports: clk, reset (sync, active-high); irq_ext (async external request),
// iret (return-from-interrupt), mask_we/mask_wd (mask write), timer_en;
// outputs s_intr1/s_intr2 (one-cycle requests), busy, pending {timer, external}.
// Optional macro INTR_TIMER_RELOAD_EN adds reload_we/reload_wd for a writable period.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter logic [9:0] TIMER_PERIOD = DEF_PERIOD,
    parameter int         SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       irq_ext,
    input  logic       iret,
    input  logic       mask_we,
    input  logic [1:0] mask_wd,
    input  logic       timer_en,
`ifdef INTR_TIMER_RELOAD_EN
    input  logic       reload_we,
    input  logic [9:0] reload_wd,
`endif
    output logic       s_intr1,
    output logic       s_intr2,
    output logic       busy,
    output logic [1:0] pending
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_d;
    logic [1:0]             r_mask;
    logic [1:0]             r_pend;
    state_t                 r_state;
    state_t                 w_next;
    logic                   r_win;
    logic                   w_tick;
    logic [1:0]             w_req;
    logic [1:0]             w_set;
    logic [1:0]             w_clr;

    intr_timer #(.PERIOD(TIMER_PERIOD)) u_timer (
        .clk         (clk),
        .reset       (reset),
        .i_en        (timer_en),
`ifdef INTR_TIMER_RELOAD_EN
        .i_reload_we (reload_we),
        .i_reload_wd (reload_wd),
`endif
        .o_tick      (w_tick)
    );

    assign w_set[SRC_EXT] = r_sync[SYNC_STAGES-1] & ~r_sync_d;
    assign w_set[SRC_TMR] = w_tick;
    assign w_req          = r_pend & r_mask;
    // r_win: 0 = external, 1 = timer
    assign w_clr   = (r_state == FIRE) ? (r_win ? 2'b10 : 2'b01) : 2'b00;
    assign pending = r_pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync   <= '0;
            r_sync_d <= 1'b0;
            r_mask   <= 2'b00;
            r_pend   <= 2'b00;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], irq_ext};
            r_sync_d <= r_sync[SYNC_STAGES-1];
            if (mask_we)
                r_mask <= mask_wd;
            // a new event in the clearing cycle keeps the bit set
            r_pend <= (r_pend & ~w_clr) | w_set;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_win   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE)
                r_win <= ~w_req[SRC_EXT];
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (|w_req) ? FIRE : IDLE;
            FIRE:    w_next = SERVICE;
            SERVICE: w_next = iret ? IDLE : SERVICE;
            default: w_next = IDLE;
        endcase
    end

    // requests come from registered state; reset masks any pulse in its own cycle
    always_comb begin
        s_intr1 = ~reset & (r_state == FIRE) & ~r_win;
        s_intr2 = ~reset & (r_state == FIRE) & r_win;
        busy    = (r_state != IDLE);
    end
endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: randomized and directed self-checking bench for intr_ctrl
module tb_intr_ctrl;
    localparam int TP = 8;
    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       reset, irq_ext, iret, mask_we, timer_en, reload_we;
    logic [1:0] mask_wd;
    logic [9:0] reload_wd;
    logic       s_intr1, s_intr2, busy;
    logic [1:0] pending;

    int n_checks = 0;
    int n_fail = 0;
    int t;
    logic o1, o2, ob;
    logic [1:0] op;
    logic rl_req;
    logic [9:0] rl_val;

    always #5 clk = ~clk;

    intr_ctrl #(.TIMER_PERIOD(10'(TP)), .SYNC_STAGES(SS)) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_ext   (irq_ext),
        .iret      (iret),
        .mask_we   (mask_we),
        .mask_wd   (mask_wd),
        .timer_en  (timer_en),
`ifdef INTR_TIMER_RELOAD_EN
        .reload_we (reload_we),
        .reload_wd (reload_wd),
`endif
        .s_intr1   (s_intr1),
        .s_intr2   (s_intr2),
        .busy      (busy),
        .pending   (pending)
    );

    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at t=%0d: got %0d expected %0d", nm, t, got, exp);
        end
    endtask

    // behavioural model: mode 0 idle, 1 issuing, 2 awaiting return
    int         m_cnt, m_per, m_mode, m_win;
    logic [1:0] m_pend, m_mask, m_req, m_clr;
    logic [7:0] m_hist;
    logic       m_valid = 1'b0;
    logic       m_tick, m_edge;

    always @(posedge clk) begin
        if (reset) begin
            m_cnt = 0; m_per = TP; m_mode = 0; m_win = 0;
            m_pend = 2'b00; m_mask = 2'b00; m_hist = 8'h00; m_valid = 1'b1;
        end else if (m_valid) begin
            // edge reaches the detector SS cycles after the input changes
            m_edge = m_hist[SS-1] & ~m_hist[SS];
            if (reload_we) begin
                m_per = (reload_wd < 2) ? 2 : int'(reload_wd);
                m_cnt = 0;
                m_tick = 1'b0;
            end else begin
                m_tick = timer_en && (m_cnt == m_per - 1);
                m_cnt = m_tick ? 0 : (timer_en ? m_cnt + 1 : m_cnt);
            end
            m_req = m_pend & m_mask;
            m_clr = (m_mode == 1) ? (m_win == 1 ? 2'b10 : 2'b01) : 2'b00;
            if (m_mode == 0) begin
                if (m_req != 0) begin
                    m_mode = 1;
                    m_win = m_req[0] ? 0 : 1;
                end
            end else if (m_mode == 1) m_mode = 2;
            else if (iret) m_mode = 0;
            m_pend = (m_pend & ~m_clr) | {m_tick, m_edge};
            if (mask_we) m_mask = mask_wd;
            m_hist = {m_hist[6:0], irq_ext};
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("s_intr1", int'(s_intr1), int'(!reset && m_mode == 1 && m_win == 0));
            chk("s_intr2", int'(s_intr2), int'(!reset && m_mode == 1 && m_win == 1));
            chk("busy", int'(busy), int'(m_mode != 0));
            chk("pending", int'(pending), int'(m_pend));
            chk("exclusive", int'(s_intr1 & s_intr2), 0);
        end
    end

    task automatic step(input logic rs, input logic irq, input logic ir,
                        input logic mwe, input logic [1:0] mwd, input logic ten);
        @(posedge clk);
        #1;
        reset = rs; irq_ext = irq; iret = ir; mask_we = mwe; mask_wd = mwd; timer_en = ten;
        reload_we = rl_req; reload_wd = rl_val; rl_req = 1'b0;
        t++;
        @(negedge clk);
        o1 = s_intr1; o2 = s_intr2; ob = busy; op = pending;
    endtask

    task automatic do_reset(input logic irq);
        for (int i = 0; i < 3; i++) step(1'b1, irq, 1'b0, 1'b0, 2'b00, 1'b0);
        t = -1;
    endtask

    int first_p, first_1, first_2, cnt1, cnt2, iret_at, b16, b17, both;
    int p2[3];

    initial begin
        reset = 1'b1; irq_ext = 1'b1; iret = 1'b0; mask_we = 1'b0; mask_wd = 2'b00;
        timer_en = 1'b0; reload_we = 1'b0; reload_wd = 10'd0; rl_req = 1'b0; rl_val = 10'd0; t = 0;

        // reset with request line high, then 50 quiet cycles with everything masked
        do_reset(1'b1);
        chk("rst_s1", int'(o1), 0);
        chk("rst_s2", int'(o2), 0);
        chk("rst_busy", int'(ob), 0);
        chk("rst_pend", int'(op), 0);
        cnt1 = 0;
        for (int c = 0; c < 50; c++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
            cnt1 += int'(o1) + int'(o2);
        end
        chk("masked_pulses", cnt1, 0);

        // external request timing
        do_reset(1'b0);
        first_p = -1; first_1 = -1;
        for (int c = 0; c < 30; c++) begin
            step(1'b0, c >= 10, c == 16, c == 0, 2'b01, 1'b0);
            if (op[0] && first_p < 0) first_p = t;
            if (o1 && first_1 < 0) first_1 = t;
            if (t == 16) b16 = int'(ob);
            if (t == 17) b17 = int'(ob);
        end
        chk("ext_pend_cycle", first_p, 13);
        chk("ext_pulse_cycle", first_1, 14);
        chk("ext_busy_16", b16, 1);
        chk("ext_busy_17", b17, 0);

        // timer pulses with return two cycles after each
        do_reset(1'b0);
        cnt2 = 0; iret_at = -10;
        for (int c = 0; c < 30; c++) begin
            step(1'b0, 1'b0, c == iret_at, c == 0, 2'b10, 1'b1);
            if (o2) begin
                if (cnt2 < 3) p2[cnt2] = t;
                cnt2++;
                iret_at = t + 2;
            end
        end
        chk("tmr_pulse0", p2[0], 9);
        chk("tmr_pulse1", p2[1], 17);
        chk("tmr_pulse2", p2[2], 25);

        // both sources pending together
        do_reset(1'b0);
        first_1 = -1; first_2 = -1; both = 0;
        for (int c = 0; c < 20; c++) begin
            step(1'b0, c >= 5, c == 11 || c == 15, c == 0, 2'b11, c < 8);
            if (o1 && first_1 < 0) first_1 = t;
            if (o2 && first_2 < 0) first_2 = t;
            both += int'(o1 & o2);
        end
        chk("prio_ext_cycle", first_1, 9);
        chk("prio_tmr_cycle", first_2, 13);
        chk("prio_both", both, 0);

        // coalescing while masked, then unmask
        do_reset(1'b0);
        cnt1 = 0;
        for (int c = 0; c < 60; c++) begin
            step(1'b0, c >= 2 && c < 12 && (c % 4) < 2, 1'b0, c == 0 || c == 30,
                 (c == 30) ? 2'b01 : 2'b00, 1'b0);
            if (t == 29) chk("coalesce_pend", int'(op), 1);
            cnt1 += int'(o1);
        end
        chk("coalesce_pulses", cnt1, 1);

`ifdef INTR_TIMER_RELOAD_EN
        do_reset(1'b0);
        cnt2 = 0; iret_at = -10;
        rl_req = 1'b1; rl_val = 10'd5;
        for (int c = 0; c < 40; c++) begin
            if (c == 20) begin rl_req = 1'b1; rl_val = 10'd1; end
            step(1'b0, 1'b0, c == iret_at, c == 0, 2'b10, 1'b1);
            if (o2) begin
                if (cnt2 < 2) p2[cnt2] = t;
                cnt2++;
                iret_at = t + 1;
            end
        end
        chk("reload_first", p2[0], 7);
        chk("reload_spacing", p2[1] - p2[0], 5);
`endif

        // randomized traffic against the model
        do_reset(1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1);
        for (int c = 0; c < 3000; c++) begin
`ifdef INTR_TIMER_RELOAD_EN
            if ($urandom_range(0, 99) == 0) begin
                rl_req = 1'b1;
                rl_val = 10'($urandom_range(0, 20));
            end
`endif
            step($urandom_range(0, 299) == 0,
                 ($urandom_range(0, 5) == 0) ? ~irq_ext : irq_ext,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 11) == 0,
                 2'($urandom_range(0, 3)),
                 $urandom_range(0, 7) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
